// File: rtl/kbd_fifo_wb_if.sv
// rtl/kbd_fifo_wb_if.sv - CPU bus signal bundle for the keyboard FIFO register block.
interface kbd_fifo_wb_if;
    logic [15:0] bus_din;
    logic [15:0] bus_dout;
    logic [15:0] bus_addr;
    logic        bus_sync;
    logic        bus_we;
    logic        bus_stb;
    logic        bus_ack;

    modport master (
        output bus_din, bus_addr, bus_sync, bus_we, bus_stb,
        input  bus_dout, bus_ack
    );

    modport slave (
        input  bus_din, bus_addr, bus_sync, bus_we, bus_stb,
        output bus_dout, bus_ack
    );
endinterface

// File: rtl/kbd_fifo_wb.sv
// rtl/kbd_fifo_wb.sv - BK keyboard status/data registers with key FIFO, vector 60/274 IRQs.
// Optional typematic autorepeat built when KBD_AUTOREPEAT_EN is defined.
module kbd_fifo_wb #(
    parameter int          DEPTH     = 8,
    parameter logic [15:0] BASE_ADDR = 16'o177660,
    parameter logic [23:0] REP_DELAY = 24'd25000000,
    parameter logic [23:0] REP_RATE  = 24'd2500000
) (
    input  logic           clk_bus,
    input  logic           bus_reset,
    kbd_fifo_wb_if.slave   bus,
    output logic           virq_req60,
    input  logic           virq_ack60,
    output logic           virq_req274,
    input  logic           virq_ack274,
    input  logic           key_strobe,
    input  logic [6:0]     key_code,
    input  logic           key_alt,
    input  logic           key_held,
    output logic           key_down
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [15:0] DATA_ADDR = BASE_ADDR + 16'd2;
    localparam logic [AW:0] CNT_FULL  = (AW + 1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_ovf, r_mask, r_ack_d, r_act_prev;
    logic          r_ack60_prev, r_ack274_prev;
    logic [6:0]    r_last_code, r_act_code;

    logic w_sel_s, w_sel_d, w_act_lvl, w_act, w_wr_s, w_rd_d;
    logic w_full, w_ready, w_key_push, w_push, w_pop, w_ovf_set, w_irq_cond;
    logic w_rep_push;
    logic [7:0] w_rep_entry, w_push_entry, w_head;
    logic w_unused;

    assign w_sel_s   = bus.bus_sync & (bus.bus_addr[15:1] == BASE_ADDR[15:1]);
    assign w_sel_d   = bus.bus_sync & (bus.bus_addr[15:1] == DATA_ADDR[15:1]) & !bus.bus_we;
    assign w_act_lvl = bus.bus_stb & (w_sel_s | w_sel_d);
    assign w_act     = w_act_lvl & !r_act_prev;
    assign w_wr_s    = w_act & w_sel_s & bus.bus_we;
    assign w_rd_d    = w_act & w_sel_d;

    assign bus.bus_ack = w_act_lvl & r_ack_d;

    assign w_head       = r_mem[r_rd_ptr];
    assign w_full       = (r_count == CNT_FULL);
    assign w_ready      = (r_count != '0);
    assign w_key_push   = key_strobe & (key_code != 7'd0);
    assign w_push_entry = w_key_push ? {key_alt, key_code} : w_rep_entry;
    assign w_pop        = w_rd_d & w_ready;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts the push.
    assign w_push       = (w_key_push | w_rep_push) & (!w_full | w_pop);
    assign w_ovf_set    = w_key_push & w_full & !w_pop;
    assign w_irq_cond   = !r_mask & w_ready & !virq_req60 & !virq_req274 & !w_pop;

    always_comb begin
        bus.bus_dout = 16'h0000;
        if (w_sel_s)
            bus.bus_dout = {r_ovf, 7'b0, w_ready, r_mask, 6'b0};
        else if (w_sel_d)
            bus.bus_dout = {9'b0, r_last_code};
    end

    always_ff @(posedge clk_bus) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_push_entry;
    end

    always_ff @(posedge clk_bus) begin
        if (bus_reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_ovf         <= 1'b0;
            r_mask        <= 1'b1;
            r_ack_d       <= 1'b0;
            r_act_prev    <= 1'b0;
            r_ack60_prev  <= 1'b0;
            r_ack274_prev <= 1'b0;
            r_last_code   <= 7'd0;
            r_act_code    <= 7'd0;
            virq_req60    <= 1'b0;
            virq_req274   <= 1'b0;
            key_down      <= 1'b0;
        end else begin
            r_ack_d       <= bus.bus_stb;
            r_act_prev    <= w_act_lvl;
            r_ack60_prev  <= virq_ack60;
            r_ack274_prev <= virq_ack274;

            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_last_code <= w_head[6:0];
            end
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;

            if (w_wr_s) begin
                r_mask <= bus.bus_din[6];
                if (bus.bus_din[15])
                    r_ovf <= 1'b0;
            end
            if (w_ovf_set)
                r_ovf <= 1'b1;

            // Any data read withdraws both requests; they re-arm from the remaining entries.
            if (w_rd_d) begin
                virq_req60  <= 1'b0;
                virq_req274 <= 1'b0;
            end else begin
                if (virq_ack60 && !r_ack60_prev)
                    virq_req60 <= 1'b0;
                if (virq_ack274 && !r_ack274_prev)
                    virq_req274 <= 1'b0;
                if (w_irq_cond) begin
                    virq_req274 <= w_head[7];
                    virq_req60  <= !w_head[7];
                end
            end

            if (key_strobe)
                r_act_code <= key_code;
            key_down <= key_held & (r_act_code != 7'd0);
        end
    end

`ifdef KBD_AUTOREPEAT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} rep_state_t;

    rep_state_t  r_rep_state;
    logic [23:0] r_rep_cnt;
    logic [7:0]  r_rep_entry;

    assign w_rep_entry = r_rep_entry;
    assign w_rep_push  = (r_rep_state != ST_IDLE) & (r_rep_cnt == 24'd0) & key_held & !key_strobe;
    assign w_unused    = ^{bus.bus_din[14:7], bus.bus_din[5:0], bus.bus_addr[0]};

    always_ff @(posedge clk_bus) begin
        if (bus_reset) begin
            r_rep_state <= ST_IDLE;
            r_rep_cnt   <= 24'd0;
            r_rep_entry <= 8'd0;
        end else if (key_strobe) begin
            if (key_code != 7'd0) begin
                r_rep_state <= ST_DELAY;
                r_rep_cnt   <= REP_DELAY - 24'd1;
                r_rep_entry <= {key_alt, key_code};
            end else begin
                r_rep_state <= ST_IDLE;
            end
        end else if (!key_held) begin
            r_rep_state <= ST_IDLE;
        end else begin
            case (r_rep_state)
                ST_DELAY, ST_REPEAT: begin
                    if (r_rep_cnt == 24'd0) begin
                        r_rep_state <= ST_REPEAT;
                        r_rep_cnt   <= REP_RATE - 24'd1;
                    end else begin
                        r_rep_cnt <= r_rep_cnt - 24'd1;
                    end
                end
                default: r_rep_state <= ST_IDLE;
            endcase
        end
    end
`else
    assign w_rep_entry = 8'd0;
    assign w_rep_push  = 1'b0;
    assign w_unused    = ^{bus.bus_din[14:7], bus.bus_din[5:0], bus.bus_addr[0], REP_DELAY, REP_RATE};
`endif
endmodule

// File: doc/kbd_fifo_wb.md
Name: kbd_fifo_wb

Overview:
- Parametrised successor of the BK keyboard register block.
- Takes already-translated key events (7-bit code plus vector-select flag) and queues them in a DEPTH-entry FIFO, so fast typing no longer loses characters.
- Exposes the BK-compatible status/data register pair on the bus, raises vector 60/274 interrupt requests per queued entry, and generates typematic autorepeat.
- Sits between the PS/2 translator and the CPU bus.

Parameters:
- DEPTH, 8: FIFO entries; power of two, 2..64.
- BASE_ADDR, 16'o177660: status register address; data register is BASE_ADDR+2.
- REP_DELAY, 24'd25000000: cycles from key press to first repeat.
- REP_RATE, 24'd2500000: cycles between subsequent repeats.

Ports:
- clk_bus  in  1  bus clock, sole clock.
- bus_reset  in  1  synchronous, active-high reset.
- bus_din  in  16  write data.
- bus_dout  out  16  read data; 0 when not selected.
- bus_addr  in  16  byte address.
- bus_sync  in  1  address valid.
- bus_we  in  1  write cycle.
- bus_stb  in  1  data strobe.
- bus_ack  out  1  cycle acknowledge.
- virq_req60  out  1  interrupt request, vector 60.
- virq_ack60  in  1  acknowledge for vector 60; rising edge counts.
- virq_req274  out  1  interrupt request, vector 274.
- virq_ack274  in  1  acknowledge for vector 274; rising edge counts.
- key_strobe  in  1  one-cycle pulse: new key press.
- key_code  in  7  ASCII code; 0 means no character.
- key_alt  in  1  entry uses vector 274 (ALT or AR2 key).
- key_held  in  1  level: the last pressed key is still down.
- key_down  out  1  mirrors key_held while the active code is nonzero.

Behaviour:
- Register selection
  - sel_s = bus_sync & bus_addr[15:1]==BASE_ADDR[15:1].
  - sel_d = bus_sync & bus_addr[15:1]==(BASE_ADDR+2)[15:1] & !bus_we.
  - Writes to the data register are not selected: no ack.
- Acknowledge: ack_d <= bus_stb each cycle; bus_ack = bus_stb & (sel_s|sel_d) & ack_d. A read therefore acks in the 2nd cycle of stb.
- Bus actions fire on the rising edge of (bus_stb & sel); a held strobe acts once.
- Status register (BASE_ADDR)
  - bit6: IRQ mask, R/W; reset 1.
  - bit7: ready = FIFO non-empty; read-only.
  - bit15: overflow, sticky; a write with din[15]=1 clears it.
  - All other bits read 0.
- Data register (BASE_ADDR+2), read-only
  - Read returns {9'b0, head code} and pops the head.
  - Read of an empty FIFO returns the last popped code, no pop.
  - Any data read clears both requests; they re-arm per the IRQ rules below.
- FIFO
  - Entry = {alt, code[6:0]}.
  - Push on key_strobe & key_code!=0.
  - Full: drop the entry, set overflow.
  - Simultaneous push and pop: both happen, count unchanged; push into full plus pop succeeds, no overflow.
  - Pointers are log2(DEPTH) bits and wrap; count is log2(DEPTH)+1 bits.
- IRQ
  - Condition: mask==0 & non-empty & neither req pending & not the cycle of a pop.
  - When the condition holds, next cycle assert req274 if head.alt, else req60.
  - Rising edge of the matching ack clears that req.
  - The request re-arms while entries remain.
  - Clearing mask (writing bit6=0) with a non-empty FIFO raises a request.
- Autorepeat
  - States: IDLE → DELAY on a pushed strobe (counter loaded with REP_DELAY-1).
  - DELAY → REPEAT at 0; push a copy of the last entry, reload REP_RATE-1.
  - REPEAT pushes on each expiry.
  - A repeat push into a full FIFO is skipped silently; overflow is not set.
  - key_held=0 → IDLE from any state.
  - A new key_strobe restarts DELAY with the new entry.
  - Strobe with code 0 → IDLE.
- key_down register
  - Set to key_held & (active code != 0) each cycle.
  - Reset value 0.
- Reset: sampled each cycle, takes priority over all events.
  - FIFO flushed, overflow=0, mask=1, req60=req274=0, repeat IDLE, last code=0, key_down=0, ack_d=0.
  - A bus cycle or ack in progress during reset is discarded.

Optional Feature:
- Macro KBD_AUTOREPEAT_EN.
- Defined: autorepeat FSM and 24-bit counter are built as above.
- Undefined: no FSM or counter; key_held only drives key_down; REP_DELAY and REP_RATE are unused; only strobes push.

Test Plan:
- Reset, read 177660 → 0o100; read 177662 → 0; no req asserted.
- Mask=0; strobe 'A'(0x41) then 'B'(0x42) → req60 raised; ack60 → req drops then re-raises; reads return 0x41, then 0x42; ready=0 after the 2nd read.
- DEPTH=8: push 9 codes → 9th dropped; status = 0x8080; drain 8 in order; write 0x8000 → overflow clears.
- Strobe code 0x31 with key_alt=1, mask=0 → virq_req274=1, virq_req60=0; data read clears req274.
- KBD_AUTOREPEAT_EN, REP_DELAY=10, REP_RATE=4: hold key 30 cycles → 1 + 1 + 4 = 6 entries of the same code; drop key_held → no further pushes.
- Push a code, assert bus_reset for one cycle during a data read → no ack; status reads 0o100; FIFO empty.
